// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: upstream sequencer for a 3x8 decoder.
// Walks the channels enabled in a latched mask. Each selected channel is held
// for DWELL clocks with en=1. The sequencer runs one sweep, or loops until stop.
// Optional feature: define DECODER_SCAN_BLANK_GAP_EN to add anti-ghosting blanking.
// With blanking, each address change is followed by one en=0 cycle.
module decoder_scan_seq #(
  parameter int ADDR_W = 3,
  parameter int DWELL  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cont,
  input  logic [2**ADDR_W-1:0]   mask,
  output logic [ADDR_W-1:0]      a,
  output logic                   en,
  output logic                   busy,
  output logic                   done
);

  localparam int N  = 2 ** ADDR_W;
  // A one-clock dwell still needs a one-bit counter, which stays at zero.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

`ifdef DECODER_SCAN_BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     mask_q;
  logic             cont_q;

  logic [ADDR_W-1:0] next_idx;
  logic              has_next;
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] start_idx;

  // Returns the index of the lowest set bit. An empty mask returns 0.
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [N-1:0] m);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

  // Finds the next enabled channel strictly above the current select.
  // Also finds the wrap target, which is the lowest enabled channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    has_next  = 1'b0;
    next_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(a))) begin
        has_next = 1'b1;
        next_idx = ADDR_W'(i);
      end
    end
    first_idx = lowest_set(mask_q);
    start_idx = lowest_set(mask);
  end

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mask_q <= '0;
      cont_q <= 1'b0;
      a      <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every branch sees pre-edge values.
      done <= 1'b0;
      if (stop) begin
        // Abort has priority over start, dwell advance and sweep end.
        state <= IDLE;
        cnt   <= '0;
        a     <= '0;
        en    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (mask != '0) begin
                mask_q <= mask;
                cont_q <= cont;
                state  <= SCAN;
                a      <= start_idx;
                en     <= 1'b1;
                busy   <= 1'b1;
                cnt    <= '0;
              end else begin
                // An empty sweep completes at once.
                done <= 1'b1;
              end
            end
          end

          SCAN: begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (has_next) begin
                a <= next_idx;
`ifdef DECODER_SCAN_BLANK_GAP_EN
                en    <= 1'b0;
                state <= BLANK;
`endif
              end else if (cont_q) begin
                a <= first_idx;
`ifdef DECODER_SCAN_BLANK_GAP_EN
                // With a single enabled channel the address does not change, so no blank cycle is inserted.
                if (first_idx != a) begin
                  en    <= 1'b0;
                  state <= BLANK;
                end
`endif
              end else begin
                state <= IDLE;
                a     <= '0;
                en    <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

`ifdef DECODER_SCAN_BLANK_GAP_EN
          BLANK: begin
            // The new address is already on a. Enable it and restart the dwell.
            state <= SCAN;
            en    <= 1'b1;
            cnt   <= '0;
          end
`endif

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed self-checking bench for decoder_scan_seq.
// u_dut runs with DWELL=2. u_dut1 runs with DWELL=1.
// The blanking sequence is exercised when DECODER_SCAN_BLANK_GAP_EN is defined.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, cont;
  logic [7:0] mask;
  logic [2:0] a;
  logic       en, busy, done;

  logic       start1, stop1, cont1;
  logic [7:0] mask1;
  logic [2:0] a1;
  logic       en1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan_seq #(.ADDR_W(3), .DWELL(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .mask(mask), .a(a), .en(en), .busy(busy), .done(done)
  );

  decoder_scan_seq #(.ADDR_W(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .cont(cont1),
    .mask(mask1), .a(a1), .en(en1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the packed outputs {a, en, busy, done} of the DWELL=2 instance.
  task automatic chk_out(input string tag, input logic [2:0] ea, input logic ee,
                         input logic eb, input logic ed);
    chk(tag, {a, en, busy, done}, {ea, ee, eb, ed});
  endtask

  logic [2:0] seq1 [8];
  logic [2:0] seq3 [8];
  logic [2:0] bseq_a [7];
  logic       bseq_e [7];

  initial begin
    seq1 = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
    seq3 = '{3'd1, 3'd1, 3'd7, 3'd7, 3'd1, 3'd1, 3'd7, 3'd7};
    bseq_a = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    bseq_e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    start = 0; stop = 0; cont = 0; mask = '0;
    start1 = 0; stop1 = 0; cont1 = 0; mask1 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Test 1: reset state, then a single sweep over mask 1010_0101.
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset1", {a1, en1, busy1, done1}, 6'b0);
    start = 1; mask = 8'b1010_0101; cont = 0;
    step();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("sweep1[%0d]", i), seq1[i], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_out("sweep1_done", 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("sweep1_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 2: an empty mask produces only a done pulse.
    start = 1; mask = 8'h00;
    step();
    start = 0;
    chk_out("empty_done", 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("empty_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 3: continuous loop over channels 1 and 7, ended by stop.
    start = 1; mask = 8'b1000_0010; cont = 1;
    step();
    start = 0; cont = 0; mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("loop[%0d]", i), seq3[i], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_out("loop_wrap", 3'd1, 1'b1, 1'b1, 1'b0);
    stop = 1;
    step();
    stop = 0;
    chk_out("loop_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 4: restarting and changing the mask mid-sweep both have no effect.
    start = 1; mask = 8'hFF; cont = 0;
    step();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("full[%0d]", i), 3'(i / 2), 1'b1, 1'b1, 1'b0);
      if (i == 2) start = 1;
      if (i == 3) begin start = 0; mask = 8'h01; cont = 1; end
      step();
    end
    chk_out("full_done", 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("full_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 4b: stop in the same cycle as a dwell advance aborts with no done pulse.
    start = 1; mask = 8'hFF; cont = 0;
    step();
    start = 0;
    chk_out("abort_a0", 3'd0, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("abort_a0b", 3'd0, 1'b1, 1'b1, 1'b0);
    stop = 1;
    step();
    stop = 0;
    chk_out("abort_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("abort_nodone", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 4c: stop together with start wins.
    start = 1; stop = 1; mask = 8'h0F;
    step();
    start = 0; stop = 0;
    chk_out("stop_vs_start", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 4d: a single channel in continuous mode holds until stop.
    start = 1; mask = 8'h10; cont = 1;
    step();
    start = 0; cont = 0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("single[%0d]", i), 3'd4, 1'b1, 1'b1, 1'b0);
      step();
    end
    stop = 1;
    step();
    stop = 0;
    chk_out("single_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 5: with DWELL=1 the address advances every clock.
    start1 = 1; mask1 = 8'hFF; cont1 = 0;
    step();
    start1 = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dw1[%0d]", i), {a1, en1, busy1, done1}, {3'(i), 3'b110});
      step();
    end
    chk("dw1_done", {a1, en1, busy1, done1}, {3'd0, 3'b001});

    // Test 5b: asynchronous reset mid-sweep clears outputs between clock edges.
    step();
    start1 = 1; start = 1; mask = 8'hFF; cont = 1;
    step();
    start1 = 0; start = 0;
    step();
    chk("pre_rst1", {a1, en1, busy1}, {3'd1, 2'b11});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst1", {a1, en1, busy1, done1}, 6'b0);
    chk_out("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("post_rst", 3'd0, 1'b0, 1'b0, 1'b0);

    // Test 6: loop over channels 0 and 1. With blanking, each address change gets one en=0 cycle.
    start = 1; mask = 8'b0000_0011; cont = 1;
    step();
    start = 0;
`ifdef DECODER_SCAN_BLANK_GAP_EN
    for (int i = 0; i < 7; i++) begin
      chk_out($sformatf("blank[%0d]", i), bseq_a[i], bseq_e[i], 1'b1, 1'b0);
      step();
    end
`else
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("noblank[%0d]", i), 3'((i / 2) % 2), 1'b1, 1'b1, 1'b0);
      step();
    end
`endif
    stop = 1;
    step();
    stop = 0;
    chk_out("final_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
